fb_port_arbiter: RTL and testbench

//  Shares one single-port synchronous framebuffer RAM between the VGA scanout

---
 rtl/fb_port_arbiter_if.sv | 60 ++++++
 rtl/fb_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fb_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fb_port_arbiter_if
//  Description : Bundle of display-read, CPU-handshake, RAM-side and
//                starvation signals for the framebuffer port arbiter.
//                The arbiter binds to the slave modport; the surrounding
//                system (fetch path, CPU, RAM) binds to the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fb_port_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 3
);
    // Display fetch path
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;

    // CPU request/acknowledge handshake
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    // Single-port synchronous RAM
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Firmware-visible starvation status
    logic              cpu_starved;
    logic              starve_clr;

    modport slave (
        input  disp_req, disp_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mem_rdata,
        input  starve_clr,
        output disp_valid, disp_data,
        output cpu_ack, cpu_rdata,
        output mem_addr, mem_we, mem_wdata,
        output cpu_starved
    );

    modport master (
        output disp_req, disp_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mem_rdata,
        output starve_clr,
        input  disp_valid, disp_data,
        input  cpu_ack, cpu_rdata,
        input  mem_addr, mem_we, mem_wdata,
        input  cpu_starved
    );
endinterface
`default_nettype wire

// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_port_arbiter
//  Description : Arbitrates one single-port synchronous framebuffer RAM
//                between display scanout reads (absolute priority, fixed
//                2-cycle latency, never stalls) and CPU accesses served in
//                free slots through a req/ack handshake. A sticky flag
//                reports prolonged CPU starvation to firmware.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_port_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 3,
    parameter int STARVE_MAX = 800
) (
    input  logic             clk,
    input  logic             rst_n,
    fb_port_arbiter_if.slave bus
);

    localparam int                 c_cnt_w       = $clog2(STARVE_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_starve_max  = c_cnt_w'(STARVE_MAX);
    localparam logic [c_cnt_w-1:0] c_starve_last = c_cnt_w'(STARVE_MAX - 1);

    // CPU transaction states: the CPU owns the RAM only in the slot that
    // moves IDLE->ISSUE; ISSUE/WAIT/ACK merely track the read latency.
    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_wait  = 2'd2;
    localparam logic [1:0] c_ack   = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               w_cpu_ack;
    logic               w_cpu_accept;
    logic               w_starving;

    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_we;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_cpu_is_write;
    logic [DATA_W-1:0]  r_cpu_rdata;

    logic               r_disp_tag1;
    logic               r_disp_tag2;
    logic               r_disp_valid;
    logic [DATA_W-1:0]  r_disp_data;

    logic [c_cnt_w-1:0] r_starve_cnt;
    logic               r_cpu_starved;

    // Next-state and handshake decode; display requests always pre-empt IDLE acceptance
    always_comb begin
        w_state_next = r_state;
        w_cpu_ack    = 1'b0;
        w_cpu_accept = 1'b0;
        case (r_state)
            c_idle: begin
                if (!bus.disp_req && bus.cpu_req) begin
                    w_cpu_accept = 1'b1;
                    w_state_next = c_issue;
                end
            end
            c_issue: w_state_next = c_wait;
            c_wait:  w_state_next = c_ack;
            c_ack: begin
                // The edge leaving ACK ignores cpu_req so a held request is not re-served
                w_cpu_ack    = 1'b1;
                w_state_next = c_idle;
            end
            default: w_state_next = c_idle;
        endcase
    end

    assign w_starving = (r_state == c_idle) && bus.cpu_req && bus.disp_req;

    // CPU transaction state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // RAM slot owner: display read, CPU access, or idle slot holding the address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr     <= '0;
            r_mem_we       <= 1'b0;
            r_mem_wdata    <= '0;
            r_cpu_is_write <= 1'b0;
        end else if (bus.disp_req) begin
            r_mem_addr <= bus.disp_addr;
            r_mem_we   <= 1'b0;
        end else if (w_cpu_accept) begin
            r_mem_addr     <= bus.cpu_addr;
            r_mem_we       <= bus.cpu_we;
            r_mem_wdata    <= bus.cpu_wdata;
            r_cpu_is_write <= bus.cpu_we;
        end else begin
            r_mem_we <= 1'b0;
        end
    end

    // CPU read data captured as the FSM enters ACK; writes leave the last read value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_rdata <= '0;
        end else if ((r_state == c_wait) && !r_cpu_is_write) begin
            r_cpu_rdata <= bus.mem_rdata;
        end
    end

    // Display slot tags follow the RAM latency; data registered on the third edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_tag1  <= 1'b0;
            r_disp_tag2  <= 1'b0;
            r_disp_valid <= 1'b0;
            r_disp_data  <= '0;
        end else begin
            r_disp_tag1  <= bus.disp_req;
            r_disp_tag2  <= r_disp_tag1;
            r_disp_valid <= r_disp_tag2;
            if (r_disp_tag2) begin
                r_disp_data <= bus.mem_rdata;
            end
        end
    end

    // Starvation counter and sticky flag; clear has priority over a simultaneous set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt  <= '0;
            r_cpu_starved <= 1'b0;
        end else if (bus.starve_clr) begin
            r_starve_cnt  <= '0;
            r_cpu_starved <= 1'b0;
        end else begin
            if (w_cpu_accept || !bus.cpu_req) begin
                r_starve_cnt <= '0;
            end else if (w_starving && (r_starve_cnt != c_starve_max)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
            if (w_starving && (r_starve_cnt == c_starve_last)) begin
                r_cpu_starved <= 1'b1;
            end
        end
    end

    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.disp_valid  = r_disp_valid;
    assign bus.disp_data   = r_disp_data;
    assign bus.cpu_ack     = w_cpu_ack;
    assign bus.cpu_rdata   = r_cpu_rdata;
    assign bus.cpu_starved = r_cpu_starved;

endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_port_arbiter
//  Description : Self-checking bench for fb_port_arbiter. A slot-level
//                reference model predicts display data, CPU acks, write
//                strobes and the starvation flag; a monitor compares them
//                with the DUT on falling edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_port_arbiter;

    localparam int AW    = 6;
    localparam int DW    = 3;
    localparam int SMAX  = 4;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst_n;

    fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fb_port_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks;
    int failures;
    int cyc;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Framebuffer RAM: one-cycle synchronous read of the registered address
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_rd;
    initial begin
        for (int a = 0; a < DEPTH; a++) ram[a] = DW'(a & 7);
        bus.mem_rdata <= '0;
        forever begin
            @(posedge clk);
            ram_rd = ram[bus.mem_addr];
            if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
            bus.mem_rdata <= ram_rd;
        end
    end

    // Reference model: decides each slot from the arbitration rules and
    // tracks memory contents as seen by slot order.
    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          dq[$];
    exp_t          cq[$];
    logic [DW-1:0] shadow [DEPTH];
    int            cpu_free_at;
    int            st_cnt;
    logic          st_flag;
    logic          exp_we;
    logic [DW-1:0] last_rd;
    bit            m_idle;
    bit            m_accept;

    initial begin
        for (int a = 0; a < DEPTH; a++) shadow[a] = DW'(a & 7);
        cyc = 0; cpu_free_at = 0; st_cnt = 0; st_flag = 1'b0; exp_we = 1'b0; last_rd = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                dq.delete();
                cq.delete();
                cpu_free_at = 0; st_cnt = 0; st_flag = 1'b0; exp_we = 1'b0; last_rd = '0;
            end else begin
                m_idle   = (cyc >= cpu_free_at);
                m_accept = 1'b0;
                exp_we   = 1'b0;
                if (bus.disp_req) begin
                    dq.push_back('{cyc + 2, shadow[bus.disp_addr]});
                end else if (bus.cpu_req && m_idle) begin
                    m_accept    = 1'b1;
                    cpu_free_at = cyc + 4;
                    if (bus.cpu_we) begin
                        shadow[bus.cpu_addr] = bus.cpu_wdata;
                        exp_we = 1'b1;
                    end else begin
                        last_rd = shadow[bus.cpu_addr];
                    end
                    cq.push_back('{cyc + 2, last_rd});
                end
                if (bus.starve_clr) begin
                    st_cnt = 0; st_flag = 1'b0;
                end else if (m_accept || !bus.cpu_req) begin
                    st_cnt = 0;
                end else if (m_idle && bus.disp_req && st_cnt < SMAX) begin
                    st_cnt++;
                    if (st_cnt == SMAX) st_flag = 1'b1;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a response
    exp_t me;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.disp_valid) begin
                if (dq.size() == 0) check("disp_valid unexpected", 32'(bus.disp_valid), 0);
                else begin
                    me = dq.pop_front();
                    check("disp_valid cycle", 32'(cyc), 32'(me.cyc));
                    check("disp_data", 32'(bus.disp_data), 32'(me.data));
                end
            end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
                void'(dq.pop_front());
                check("disp_valid missing", 32'(bus.disp_valid), 1);
            end
            if (bus.cpu_ack) begin
                if (cq.size() == 0) check("cpu_ack unexpected", 32'(bus.cpu_ack), 0);
                else begin
                    me = cq.pop_front();
                    check("cpu_ack cycle", 32'(cyc), 32'(me.cyc));
                    check("cpu_rdata", 32'(bus.cpu_rdata), 32'(me.data));
                end
            end else if (cq.size() > 0 && cq[0].cyc <= cyc) begin
                void'(cq.pop_front());
                check("cpu_ack missing", 32'(bus.cpu_ack), 1);
            end
            check("mem_we", 32'(bus.mem_we), 32'(exp_we));
            check("cpu_starved", 32'(bus.cpu_starved), 32'(st_flag));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.cpu_ack && n < 20);
        check({name, " ack within bound"}, 32'(bus.cpu_ack), 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " disp_valid"},  32'(bus.disp_valid), 0);
        check({tag, " disp_data"},   32'(bus.disp_data), 0);
        check({tag, " cpu_ack"},     32'(bus.cpu_ack), 0);
        check({tag, " cpu_rdata"},   32'(bus.cpu_rdata), 0);
        check({tag, " mem_addr"},    32'(bus.mem_addr), 0);
        check({tag, " mem_we"},      32'(bus.mem_we), 0);
        check({tag, " mem_wdata"},   32'(bus.mem_wdata), 0);
        check({tag, " cpu_starved"}, 32'(bus.cpu_starved), 0);
    endtask

    task automatic cpu_op(input logic we, input int addr, input int wdata);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = AW'(addr);
        bus.cpu_wdata = DW'(wdata);
    endtask

    int pd;

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        bus.disp_req = 1'b0; bus.disp_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.starve_clr = 1'b0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // Back-to-back display reads of addresses 0..9
        for (int a = 0; a < 10; a++) begin
            bus.disp_req = 1'b1; bus.disp_addr = AW'(a);
            tick();
        end
        bus.disp_req = 1'b0;
        repeat (4) tick();

        // CPU write then read-back with an idle display, req held through ack
        cpu_op(1'b1, 5, 3);
        wait_ack("wr5");
        tick();
        bus.cpu_req = 1'b0;
        tick();
        cpu_op(1'b0, 5, 0);
        wait_ack("rd5");
        check("rd5 cpu_rdata", 32'(bus.cpu_rdata), 3);
        tick();
        bus.cpu_req = 1'b0;
        repeat (2) tick();

        // CPU blocked by continuous display, served in a one-cycle gap
        bus.disp_req = 1'b1;
        cpu_op(1'b1, 9, 5);
        repeat (6) begin
            bus.disp_addr = AW'($urandom_range(0, DEPTH - 1));
            tick();
        end
        bus.disp_req = 1'b0;
        tick();
        bus.disp_req = 1'b1; bus.disp_addr = AW'(9);
        wait_ack("gap");
        bus.cpu_req = 1'b0; bus.disp_req = 1'b0;
        tick();

        // Starvation flag: set after SMAX denied edges, sticky, cleared by pulse
        bus.starve_clr = 1'b1;
        tick();
        bus.starve_clr = 1'b0;
        check("starved after clr", 32'(bus.cpu_starved), 0);
        bus.disp_req = 1'b1; bus.disp_addr = AW'(1);
        cpu_op(1'b0, 1, 0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("starved ramp", 32'(bus.cpu_starved), (i >= SMAX) ? 32'd1 : 32'd0);
        end
        bus.disp_req = 1'b0;
        wait_ack("starve serve");
        check("starved sticky", 32'(bus.cpu_starved), 1);
        bus.cpu_req = 1'b0; bus.starve_clr = 1'b1;
        tick();
        bus.starve_clr = 1'b0;
        check("starved cleared", 32'(bus.cpu_starved), 0);
        repeat (2) tick();

        // Display read one slot after a CPU write returns the new data
        cpu_op(1'b1, 7, 6);
        tick();
        bus.disp_req = 1'b1; bus.disp_addr = AW'(7);
        tick();
        bus.disp_req = 1'b0;
        tick();
        check("wr7 ack", 32'(bus.cpu_ack), 1);
        bus.cpu_req = 1'b0;
        tick();
        check("rd-after-wr valid", 32'(bus.disp_valid), 1);
        check("rd-after-wr data", 32'(bus.disp_data), 6);
        repeat (3) tick();

        // Asynchronous reset while a CPU read is in ISSUE: no ack may follow
        cpu_op(1'b0, 2, 0);
        tick();
        #2;
        rst_n = 1'b0;
        bus.cpu_req = 1'b0;
        #1;
        check_zero("mid-issue reset");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) begin
            tick();
            check("post-reset cpu_ack", 32'(bus.cpu_ack), 0);
        end

        // Randomised traffic: light then heavy display load
        for (int i = 0; i < 3000; i++) begin
            pd = (i < 1500) ? 40 : 85;
            bus.disp_req   = ($urandom_range(0, 99) < pd);
            bus.disp_addr  = AW'($urandom_range(0, DEPTH - 1));
            bus.starve_clr = ($urandom_range(0, 99) < 2);
            if (!bus.cpu_req) begin
                if ($urandom_range(0, 99) < 30)
                    cpu_op(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom_range(0, 7));
            end else if (bus.cpu_ack) begin
                if ($urandom_range(0, 99) < 70) bus.cpu_req = 1'b0;
            end else if ($urandom_range(0, 99) < 3) begin
                bus.cpu_req = 1'b0;
            end
            tick();
        end

        bus.disp_req = 1'b0; bus.cpu_req = 1'b0; bus.starve_clr = 1'b0;
        repeat (8) tick();
        check("display responses outstanding", 32'(dq.size()), 0);
        check("cpu responses outstanding", 32'(cq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
